// File: rtl/datawidthconv_pkg.sv
// Shared definitions for the narrow-to-wide read converter: FSM state
// encoding and the supported read-latency range.
package datawidthconv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT_RD = 2'd2,
    DRAIN   = 2'd3
  } dwc_state_t;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/simple_dualportram.sv
// One write port, one registered read port. DEPTH is the address width;
// the read register holds its value while rd_en_i is low.
module simple_dualportram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [DEPTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [DEPTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/datawidthconv_n_to_wide.sv
// Fetches burst_len*RATIO narrow words from a fixed-latency read port, packs
// each group of RATIO into one wide word, buffers them, then streams them out.
module datawidthconv_n_to_wide
  import datawidthconv_pkg::*;
#(
  parameter  int IN_W         = 32,
  parameter  int RATIO        = 16,
  parameter  int MAX_BURST    = 32,
  parameter  int READ_LATENCY = 1,
  localparam int OUT_W        = IN_W * RATIO,
  localparam int LEN_W        = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_req,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             msb_first,
  output logic [31:0]      data_addr,
  output logic             data_oe,
  input  logic [IN_W-1:0]  data_q,
  output logic             src_valid,
  input  logic             src_ready,
  output logic             src_sop,
  output logic             src_eop,
  output logic [OUT_W-1:0] src_q,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int AW    = $clog2(MAX_BURST);
  localparam int LW    = $clog2(RATIO);
  localparam int CNT_W = LEN_W + LW;
  localparam int STEP  = IN_W / 8;
  // Out-of-range latencies are clamped into the supported window.
  localparam int RL = (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                      (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  dwc_state_t       state_q, state_d;
  logic             req_prev_q;
  logic [LEN_W-1:0] len_q;
  logic             msb_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [RL-1:0]    vld_q;
  logic [LW-1:0]    lane_q;
  logic [LEN_W-1:0] grp_q;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] rd_ptr_q;
  logic             valid_q, sop_q, eop_q;

  logic             req_rise, len_ok, start, rd_last;
  logic             capture, grp_done, last_wr, load, xfer;
  logic [CNT_W-1:0] rd_total;
  logic [LW-1:0]    lane_sel;
  logic [OUT_W-1:0] ram_rd_data;

  assign req_rise = src_req & ~req_prev_q;
  assign len_ok   = (burst_len != '0) && (burst_len <= LEN_W'(MAX_BURST));
  assign start    = (state_q == IDLE) && req_rise && len_ok;
  assign rd_total = CNT_W'(len_q) * CNT_W'(RATIO);
  assign rd_last  = (rd_cnt_q == rd_total - CNT_W'(1));
  assign capture  = vld_q[RL-1];
  assign lane_sel = msb_q ? (LW'(RATIO - 1) - lane_q) : lane_q;
  assign grp_done = capture && (lane_q == LW'(RATIO - 1));
  assign last_wr  = grp_done && (grp_q == len_q - LEN_W'(1));

  // Output handshake: a word transfers on any cycle with src_valid and
  // src_ready both high; while src_valid is high and src_ready low the RAM
  // read register is not reloaded, so src_q/src_sop/src_eop hold. A new word
  // is loaded when the output slot is empty or being emptied this cycle.
  assign xfer = valid_q && src_ready;
  assign load = (state_q == DRAIN) && (rd_ptr_q != len_q) && (!valid_q || src_ready);

  always_comb begin
    acc_d = acc_q;
    if (capture) acc_d[IN_W*lane_sel +: IN_W] = data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)          state_d = FETCH;
      FETCH:   if (rd_last)        state_d = WAIT_RD;
      WAIT_RD: if (last_wr)        state_d = DRAIN;
      DRAIN:   if (xfer && eop_q)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // req_prev_q resets high so a request held through reset needs a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b1;
      len_q      <= '0;
      msb_q      <= 1'b0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      vld_q      <= '0;
      lane_q     <= '0;
      grp_q      <= '0;
      acc_q      <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= src_req;
      vld_q[0]   <= data_oe;
      for (int i = 1; i < RL; i++) vld_q[i] <= vld_q[i-1];
      if (start) begin
        len_q    <= burst_len;
        msb_q    <= msb_first;
        addr_q   <= base_addr;
        rd_cnt_q <= '0;
        lane_q   <= '0;
        grp_q    <= '0;
        rd_ptr_q <= '0;
      end
      if (state_q == FETCH) begin
        addr_q   <= addr_q + 32'(STEP);
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (capture) begin
        acc_q  <= acc_d;
        lane_q <= grp_done ? '0 : lane_q + LW'(1);
        if (grp_done) grp_q <= grp_q + LEN_W'(1);
      end
      if (load) begin
        valid_q  <= 1'b1;
        sop_q    <= (rd_ptr_q == '0);
        eop_q    <= (rd_ptr_q == len_q - LEN_W'(1));
        rd_ptr_q <= rd_ptr_q + LEN_W'(1);
      end else if (xfer) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

  simple_dualportram #(
    .WIDTH (OUT_W),
    .DEPTH (AW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (grp_done),
    .wr_addr_i (grp_q[AW-1:0]),
    .wr_data_i (acc_d),
    .rd_en_i   (load),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (ram_rd_data)
  );

  assign data_oe   = (state_q == FETCH);
  assign data_addr = addr_q;
  assign src_valid = valid_q;
  assign src_sop   = sop_q;
  assign src_eop   = eop_q;
  assign src_q     = ram_rd_data;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/datawidthconv_n_to_wide.md
DATAWIDTHCONV_N_TO_WIDE -- requirements
Module: datawidthconv_n_to_wide

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, giving the narrow read data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter RATIO, default 16, giving the number of narrow words per wide word; OUT_W = IN_W*RATIO.
REQ-003 The block SHALL have parameter MAX_BURST, default 32, giving the maximum wide words per burst (power of 2).
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, giving the fixed cycles from data_oe to valid data_q (1..4).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 src_req  input  1  start request; its rising edge starts a burst.
REQ-008 base_addr  input  32  byte address of the first narrow word; sampled at start.
REQ-009 burst_len  input  $clog2(MAX_BURST)+1  wide words to produce; sampled at start.
REQ-010 msb_first  input  1  lane order mode; sampled at start.
REQ-011 data_addr  output  32  narrow read byte address.
REQ-012 data_oe  output  1  narrow read strobe, one read per high cycle.
REQ-013 data_q  input  IN_W  narrow read data.
REQ-014 src_valid / src_ready  output / input  1 / 1  wide output handshake.
REQ-015 src_sop / src_eop  output  1 / 1  first / last wide word of burst.
REQ-016 src_q  output  OUT_W  wide data.
REQ-017 busy  output  1  high from start until the eop transfer completes.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT_RD, DRAIN.
REQ-019 In IDLE, a rising edge of src_req with burst_len in 1..MAX_BURST SHALL latch base_addr, burst_len and msb_first, set busy and enter FETCH; burst_len 0 or >MAX_BURST SHALL be ignored.
REQ-020 src_req edges outside IDLE SHALL be ignored.
REQ-021 In FETCH, data_oe SHALL be high every cycle for exactly burst_len*RATIO cycles, with data_addr = base + k*(IN_W/8) for read k, wrapping modulo 2^32.
REQ-022 data_q SHALL be captured exactly READ_LATENCY cycles after each data_oe cycle, tracked by a READ_LATENCY-deep valid shift register.
REQ-023 With msb_first=0, narrow word j of a group SHALL occupy src_q bits [IN_W*j +: IN_W]; with msb_first=1, bits [IN_W*(RATIO-1-j) +: IN_W].
REQ-024 Each completed group of RATIO narrow words SHALL be written as one wide word to buffer address (group index).
REQ-025 WAIT_RD SHALL hold until the last captured narrow word is written, then enter DRAIN.
REQ-026 In DRAIN, the block SHALL present burst_len words in write order; the first src_valid SHALL assert no later than 3 cycles after the last buffer write.
REQ-027 A transfer SHALL occur on a cycle with src_valid and src_ready both high; with src_ready held high, one word per cycle with no bubbles.
REQ-028 While src_valid is high and src_ready low, src_q, src_sop and src_eop SHALL hold stable.
REQ-029 src_sop SHALL be high only with the first word, src_eop only with the last; both high together when burst_len=1.
REQ-030 After the eop transfer, the block SHALL deassert src_valid and busy next cycle and return to IDLE.

Reset
REQ-031 When reset is low, the FSM SHALL go to IDLE and data_addr, data_oe, src_valid, src_sop, src_eop, src_q, busy SHALL be 0 immediately.
REQ-032 Reset mid-burst SHALL abandon the burst; read data arriving after reset release SHALL be discarded.
REQ-033 A src_req held high through reset release SHALL NOT start a burst; a fresh rising edge is required.

Structure
REQ-034 A shared package datawidthconv_pkg SHALL hold the FSM state enum and the READ_LATENCY bound.
REQ-035 The wide buffer SHALL be one simple_dualportram instance, WIDTH=OUT_W, DEPTH=$clog2(MAX_BURST).

Verification
REQ-036 Defaults, base 0, len 32, memory returns word k = k, ready=1 -> 512 reads, addr 0..0x7FC; 32 outputs, word n lane j = 16n+j; sop on n=0, eop on n=31.
REQ-037 len 1, msb_first=1, base 0x100 -> 16 reads at 0x100..0x13C; one output with sop=eop=1, lane 15 = first word read.
REQ-038 len 4, src_ready toggling 1-0-0-1 -> exactly 4 transfers, data/sop/eop stable across stalls, no loss or duplication.
REQ-039 READ_LATENCY=3, len 2 -> output identical to latency-1 run with same memory contents.
REQ-040 Reset low during FETCH at read 100 -> outputs 0 at once; after release no src_valid until new src_req edge; next burst correct.
REQ-041 len 0 and len 33 requests -> no data_oe, busy stays 0; src_req edge during DRAIN -> ignored, single burst output.
